// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: reset vector, instruction loader states and the
// byte-lane swap used between big-endian program images and the fetch port.
package mips_cpu_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/mips_cpu_instr_loader.sv
// Byte-serial program loader: assembles big-endian bytes into words and emits
// array writes until load_last arrives or the array is full.
//
// state | meaning
// IDLE  | no load since reset, bytes ignored
// LOAD  | accepting bytes, load_ready high
// DONE  | load finished (normally or on full array), bytes ignored
module mips_cpu_instr_loader
    import mips_cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             load_start,
    input  logic                             load_valid,
    input  logic [7:0]                       load_byte,
    input  logic                             load_last,
    output logic                             load_ready,
    output logic                             loaded,
    output logic                             load_error,
    output logic [$clog2(DEPTH_WORDS):0]     word_count,
    output logic                             load_active,
    output logic                             wr_en,
    output logic [$clog2(DEPTH_WORDS)-1:0]   wr_addr,
    output logic [31:0]                      wr_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH_WORDS - 1);

    loader_state_t state_q, state_d;
    logic [AW-1:0] ptr_q;
    logic [1:0]    byte_idx_q;
    logic [31:0]   asm_q;
    logic          accept;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        // Unfilled low bytes are still zero in asm_q, which gives the padding.
        wr_data = asm_q | ({load_byte, 24'h000000} >> {byte_idx_q, 3'b000});
        case (state_q)
            IDLE: begin
                if (load_start) state_d = LOAD;
            end
            LOAD: begin
                if (load_start) begin
                    state_d = LOAD;
                end else if (load_valid) begin
                    accept = 1'b1;
                    wr_en  = (byte_idx_q == 2'd3) || load_last;
                    if (load_last)
                        state_d = DONE;
                    else if (byte_idx_q == 2'd3 && ptr_q == LAST_PTR)
                        state_d = DONE;
                end
            end
            DONE: begin
                if (load_start) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_ready  = (state_q == LOAD);
    assign load_active = (state_q == LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            loaded     <= 1'b0;
            load_error <= 1'b0;
            word_count <= '0;
        end else begin
            state_q <= state_d;
            if (load_start) begin
                ptr_q      <= '0;
                byte_idx_q <= '0;
                asm_q      <= '0;
                loaded     <= 1'b0;
                load_error <= 1'b0;
            end else if (accept) begin
                if (wr_en) begin
                    asm_q      <= '0;
                    byte_idx_q <= '0;
                    ptr_q      <= ptr_q + 1'b1;
                    if (load_last) begin
                        loaded     <= 1'b1;
                        word_count <= {1'b0, ptr_q} + (AW + 1)'(1);
                    end else if (ptr_q == LAST_PTR) begin
                        loaded     <= 1'b1;
                        load_error <= 1'b1;
                        word_count <= (AW + 1)'(DEPTH_WORDS);
                    end
                end else begin
                    asm_q      <= wr_data;
                    byte_idx_q <= byte_idx_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mips_cpu_instr_memory.sv
// Instruction-side memory: word array at BASE_ADDR filled by the byte loader,
// read combinationally by the CPU fetch port in CPU byte-lane order.
module mips_cpu_instr_memory
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
    parameter int          DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    instr_address,
    output logic [31:0]                    instr_readdata,
    output logic                           fetch_fault,
    input  logic                           load_start,
    input  logic                           load_valid,
    input  logic [7:0]                     load_byte,
    input  logic                           load_last,
    output logic                           load_ready,
    output logic                           loaded,
    output logic                           load_error,
    output logic [$clog2(DEPTH_WORDS):0]   word_count
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          load_active;
    logic [29:0]   word_off;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          aligned;

    mips_cpu_instr_loader #(.DEPTH_WORDS(DEPTH_WORDS)) u_loader (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_byte   (load_byte),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .loaded      (loaded),
        .load_error  (load_error),
        .word_count  (word_count),
        .load_active (load_active),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Word-granular offset; addresses below BASE_ADDR wrap high and fall out of range.
    assign word_off = instr_address[31:2] - BASE_ADDR[31:2];
    assign idx      = word_off[AW-1:0];
    assign in_range = word_off < 30'(DEPTH_WORDS);
    assign aligned  = (instr_address[1:0] == 2'b00);

    assign instr_readdata = (in_range && aligned && !load_active) ? bswap32(mem[idx]) : 32'h0;
    assign fetch_fault    = !aligned || (in_range && load_active);

endmodule

// File: doc/mips_cpu_instr_memory.md
# mips_cpu_instr_memory

Instruction-side memory responder for `mips_cpu_harvard`: it answers the CPU instruction-fetch port (`instr_address` to `instr_readdata`) from an internal word array mapped at the reset vector. The array is filled through a byte-serial valid/ready loader port, so benches and the system top can stream a program in instead of hard-coding an address decoder. It sits beside `mips_cpu_data_memory`, which owns the data side.

## Interface
- `BASE_ADDR`, default 32'hBFC00000: byte address of word 0.
- `DEPTH_WORDS`, default 64: array depth in words, power of two.
- `clk` input, 1: the single clock; all state updates on its rising edge.
- `reset` input, 1: synchronous, active-high.
- `instr_address` input, 32: CPU fetch byte address.
- `instr_readdata` output, 32: fetched word, delivered in the CPU's byte-lane order.
- `fetch_fault` output, 1: the current fetch is misaligned, or in range while a load is in progress.
- `load_start` input, 1: one-cycle pulse that begins or restarts a load.
- `load_valid` input, 1: `load_byte` is valid this cycle.
- `load_byte` input, 8: program byte, big-endian stream order.
- `load_last` input, 1: qualifies the final byte of the stream.
- `load_ready` output, 1: the loader accepts a byte this cycle.
- `loaded` output, 1: a load has completed.
- `load_error` output, 1: the array filled before `load_last` arrived.
- `word_count` output, $clog2(DEPTH_WORDS)+1: number of words written by the last load.

## Operation
- Loader FSM states: IDLE, LOAD, DONE.
- IDLE → LOAD on `load_start`. This clears `ptr`, `byte_idx`, `loaded` and `load_error`.
- A byte is accepted when `load_valid && load_ready`. Accepted bytes fill the assembly register MSB first: `byte_idx` 0 → [31:24], then [23:16], [15:8], [7:0].
- On acceptance at `byte_idx`==3, the word is written to `mem[ptr]`, `ptr` increments and `byte_idx` wraps to 0.
- Accepting a byte with `load_last` writes the current word immediately, padding any unfilled low bytes with 0. The FSM then goes to DONE with `loaded`=1 and `word_count` = words written.
- Full array: a write to `mem[DEPTH_WORDS-1]` without `load_last` goes to DONE with `loaded`=1 and `load_error`=1.
- `load_ready` = 1 only in LOAD. Bytes offered in IDLE or DONE are ignored.
- `load_start` in LOAD or DONE restarts the load. Words already written stay in the array.
- `load_start` and `load_valid` in the same cycle: the restart wins and the byte is dropped.
- Fetch path is combinational. `idx` = (`instr_address` − `BASE_ADDR`) >> 2. The fetch is in range when `idx` < `DEPTH_WORDS`.
- `instr_readdata` = `{w[7:0], w[15:8], w[23:16], w[31:24]}` of `mem[idx]` when the fetch is in range, aligned and the FSM is not in LOAD. Otherwise `instr_readdata` = 0, which is a NOP.
- `fetch_fault` = `instr_address[1:0]` != 0, or (in range and FSM in LOAD).
- Out-of-range addresses, including 0 (the CPU halt address), return 0 with `fetch_fault`=0.

## Timing
- Reset (synchronous, 1 cycle) sets:
  - all array words to 0;
  - FSM to IDLE, `ptr`=0, `byte_idx`=0;
  - `load_ready`=0, `loaded`=0, `load_error`=0, `word_count`=0.
- During reset `instr_readdata` follows the cleared array, so it reads 0.
- Reset asserted mid-load aborts the load and clears the array.
- Latency from `load_start` to `load_ready`=1 is one cycle.
- A word written at edge N is visible on `instr_readdata` from edge N onward (combinational read after the write).
- Sustained throughput: 1 byte per cycle, so 4 cycles per word.
- `loaded`, `load_error` and `word_count` update on the same edge as the final write.

## Structure
- `mips_cpu_pkg` holds: `RESET_VECTOR` (32'hBFC00000), the `loader_state_t` enum, and the `bswap32` function that the CPU and benches also use.
- Sub-module `mips_cpu_instr_loader` contains the FSM, `byte_idx`/`ptr` counters and the assembly register. It emits a write enable, write address and write data.
- The top holds the array and the fetch decode.

## Test plan
- Reset, then fetch 32'hBFC00000 → `instr_readdata`=0, `fetch_fault`=0, `load_ready`=0.
- Stream 32 bytes holding the 8 DIVU test words, `load_last` on byte 32:
  - `word_count`=8, `loaded`=1, `load_error`=0;
  - fetch 32'hBFC00008 → `bswap32`(32'h00A4001A) = 32'h1A00A400.
- Stream 6 bytes 01 02 03 04 05 06 with `load_last` on 06 → word 1 = 32'h05060000, `word_count`=2.
- Stream 4·`DEPTH_WORDS` bytes without `load_last`:
  - `load_error`=1 after the final word;
  - `load_ready`=0 afterwards;
  - extra bytes are ignored.
- Fetches of 32'hBFC00002, and of an in-range address during LOAD → `fetch_fault`=1, data 0. Fetch of 0 → data 0, `fetch_fault`=0.
- Assert `reset` after 10 accepted bytes:
  - next cycle IDLE, all flags 0;
  - fetch 32'hBFC00000 returns 0;
  - `load_start` with `load_valid` drops the byte.
